// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide sequencer owning all HI/LO register writes.
// Latency: MULT/MULTU/DIV/DIVU write at N+ITER+1 after accepting start at edge N; MTHI/MTLO and divide-by-zero write at N+1.
// Backpressure: busy holds off new work; stall is raised to the front end for any start or MFHI/MFLO while busy.
module mdu_ctrl #(
  parameter int ITER = 32
) (
  input  logic        MDU_clk,
  input  logic        MDU_rst_n,
  input  logic        MDU_ena,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mf_req,
  output logic [31:0] HI_wdata,
  output logic [31:0] LO_wdata,
  output logic        HI_w,
  output logic        LO_w,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   count;
  logic [63:0]     acc;        // mul: {partial HI, shifting multiplier}; div: {remainder, shifting quotient}
  logic [31:0]     opnd;       // multiplicand or divisor magnitude
  logic            is_div_q;
  logic            neg_q;      // negate product / quotient
  logic            neg_r;      // negate remainder (dividend was negative)
  logic            hi_w_q;
  logic            lo_w_q;
  logic            done_q;

  // instruction decode and operand magnitudes
  logic        is_mul, is_dv, is_mt, div0, take, sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  // one iteration of the active algorithm and the sign-corrected final result
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [63:0] step;
  logic [63:0] prod_fix;
  logic [31:0] fin_hi, fin_lo;

  // decode the incoming instruction and form operand magnitudes
  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    is_dv  = (op == OP_DIV)  || (op == OP_DIVU);
    is_mt  = (op == OP_MTHI) || (op == OP_MTLO);
    div0   = is_dv && (rt_data == 32'd0);
    take   = start && (is_mul || is_dv || is_mt);
    sgn    = (op == OP_MULT) || (op == OP_DIV);
    a_neg  = sgn && rs_data[31];
    b_neg  = sgn && rt_data[31];
    a_mag  = a_neg ? (~rs_data + 32'd1) : rs_data;
    b_mag  = b_neg ? (~rt_data + 32'd1) : rt_data;
  end

  // shift-add or restoring-divide step, plus sign fixup of the finished value
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    rem_sh  = acc[63:31];
    trial   = rem_sh - {1'b0, opnd};
    if (is_div_q) begin
      if (!trial[32]) step = {trial[31:0], acc[30:0], 1'b1};
      else            step = {rem_sh[31:0], acc[30:0], 1'b0};
    end else begin
      step = {mul_sum, acc[31:1]};
    end
    prod_fix = neg_q ? (~step + 64'd1) : step;
    if (is_div_q) begin
      fin_lo = neg_q ? (~step[31:0] + 32'd1) : step[31:0];
      fin_hi = neg_r ? (~step[63:32] + 32'd1) : step[63:32];
    end else begin
      fin_lo = prod_fix[31:0];
      fin_hi = prod_fix[63:32];
    end
  end

  // state register; a low enable freezes the sequencer
  always_ff @(posedge MDU_clk) begin
    if (!MDU_rst_n)   state <= IDLE;
    else if (MDU_ena) state <= state_nxt;
  end

  // next-state decode and combinational handshake outputs
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    stall     = busy && (start || mf_req);
    unique case (state)
      IDLE:  if (take) state_nxt = (is_mt || div0) ? WRITE : CALC;
      CALC:  if (count == LAST) state_nxt = WRITE;
      WRITE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture, iteration datapath and registered write port
  always_ff @(posedge MDU_clk) begin
    if (!MDU_rst_n) begin
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      HI_wdata <= '0;
      LO_wdata <= '0;
      hi_w_q   <= 1'b0;
      lo_w_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (MDU_ena) begin
      hi_w_q <= 1'b0;
      lo_w_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            count <= '0;
            if (op == OP_MTHI) begin
              HI_wdata <= rs_data;
              hi_w_q   <= 1'b1;
              done_q   <= 1'b1;
            end else if (op == OP_MTLO) begin
              LO_wdata <= rs_data;
              lo_w_q   <= 1'b1;
              done_q   <= 1'b1;
            end else if (div0) begin
              HI_wdata <= rs_data;
              LO_wdata <= 32'hFFFF_FFFF;
              hi_w_q   <= 1'b1;
              lo_w_q   <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              is_div_q <= is_dv;
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              acc      <= is_dv ? {32'd0, a_mag} : {32'd0, b_mag};
              opnd     <= is_dv ? b_mag : a_mag;
            end
          end
        end
        CALC: begin
          acc   <= step;
          count <= count + 1'b1;
          if (count == LAST) begin
            HI_wdata <= fin_hi;
            LO_wdata <= fin_lo;
            hi_w_q   <= 1'b1;
            lo_w_q   <= 1'b1;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign HI_w = hi_w_q && MDU_ena;
  assign LO_w = lo_w_q && MDU_ena;
  assign done = done_q && MDU_ena;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed bench for the HI/LO multiply/divide sequencer.
// Latency: checks write timing relative to the accepting edge for every op class.
// Backpressure: exercises stall, ignored starts, reset abort and enable freeze.
module tb_mdu_ctrl;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic        MDU_clk = 1'b0;
  logic        MDU_rst_n;
  logic        MDU_ena;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mf_req;
  logic [31:0] HI_wdata;
  logic [31:0] LO_wdata;
  logic        HI_w;
  logic        LO_w;
  logic        busy;
  logic        stall;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  mdu_ctrl #(.ITER(32)) dut (
    .MDU_clk  (MDU_clk),
    .MDU_rst_n(MDU_rst_n),
    .MDU_ena  (MDU_ena),
    .start    (start),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .mf_req   (mf_req),
    .HI_wdata (HI_wdata),
    .LO_wdata (LO_wdata),
    .HI_w     (HI_w),
    .LO_w     (LO_w),
    .busy     (busy),
    .stall    (stall),
    .done     (done)
  );

  always #5 MDU_clk = ~MDU_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge MDU_clk);
    #1;
  endtask

  // present one instruction for one edge; returns in cycle N+1
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    tick();
    start   = 1'b0;
  endtask

  // sample cycles 1..ncyc (relative to the current cycle = 1), capturing the first write
  task automatic observe(input int ncyc, output int wr_cyc, output int n_wr, output int n_busy,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output logic hw, output logic lw, output logic dn);
    wr_cyc = 0; n_wr = 0; n_busy = 0; hi = '0; lo = '0; hw = 0; lw = 0; dn = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) tick();
      if (busy) n_busy++;
      if (HI_w || LO_w) begin
        n_wr++;
        if (wr_cyc == 0) begin
          wr_cyc = c; hi = HI_wdata; lo = LO_wdata; hw = HI_w; lw = LO_w; dn = done;
        end
      end
    end
  endtask

  task automatic test_reset();
    MDU_rst_n = 1'b0; start = 1'b1; mf_req = 1'b1; op = OP_MULT;
    tick(); tick();
    vectors++; if (HI_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_hi: got %h expected 00000000", HI_wdata); end
    vectors++; if (LO_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_lo: got %h expected 00000000", LO_wdata); end
    vectors++; if ({HI_w, LO_w, done} !== 3'b000) begin miscompares++; $display("FAIL reset_we: got %b expected 000", {HI_w, LO_w, done}); end
    vectors++; if ({busy, stall} !== 2'b00) begin miscompares++; $display("FAIL reset_busy_stall: got %b expected 00", {busy, stall}); end
    start = 1'b0; mf_req = 1'b0; MDU_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int wc, nw, nb; logic [31:0] hi, lo; logic hw, lw, dn;
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    observe(34, wc, nw, nb, hi, lo, hw, lw, dn);
    vectors++; if (wc !== 33) begin miscompares++; $display("FAIL mult_wr_cycle: got %0d expected 33", wc); end
    vectors++; if (nw !== 1) begin miscompares++; $display("FAIL mult_wr_count: got %0d expected 1", nw); end
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    vectors++; if (lo !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL mult_lo: got %h expected fffffffe", lo); end
    vectors++; if ({hw, lw, dn} !== 3'b111) begin miscompares++; $display("FAIL mult_we_done: got %b expected 111", {hw, lw, dn}); end
  endtask

  task automatic test_multu();
    int wc, nw, nb; logic [31:0] hi, lo; logic hw, lw, dn;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    observe(34, wc, nw, nb, hi, lo, hw, lw, dn);
    vectors++; if (hi !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_hi: got %h expected 00000001", hi); end
    vectors++; if (lo !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_lo: got %h expected fffffffe", lo); end
    vectors++; if (nb !== 33) begin miscompares++; $display("FAIL multu_busy_cycles: got %0d expected 33", nb); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL multu_busy_fall: got %b expected 0", busy); end
  endtask

  task automatic test_div();
    int wc, nw, nb; logic [31:0] hi, lo; logic hw, lw, dn;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    observe(34, wc, nw, nb, hi, lo, hw, lw, dn);
    vectors++; if (wc !== 33) begin miscompares++; $display("FAIL div_wr_cycle: got %0d expected 33", wc); end
    vectors++; if (lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_quot: got %h expected fffffffd", lo); end
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_rem: got %h expected ffffffff", hi); end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    observe(34, wc, nw, nb, hi, lo, hw, lw, dn);
    vectors++; if (lo !== 32'h8000_0000) begin miscompares++; $display("FAIL div_ovf_quot: got %h expected 80000000", lo); end
    vectors++; if (hi !== 32'h0000_0000) begin miscompares++; $display("FAIL div_ovf_rem: got %h expected 00000000", hi); end
  endtask

  task automatic test_div_by_zero();
    int wc, nw, nb; logic [31:0] hi, lo; logic hw, lw, dn;
    issue(OP_DIVU, 32'd7, 32'd0);
    observe(2, wc, nw, nb, hi, lo, hw, lw, dn);
    vectors++; if (wc !== 1) begin miscompares++; $display("FAIL div0_wr_cycle: got %0d expected 1", wc); end
    vectors++; if (hi !== 32'd7) begin miscompares++; $display("FAIL div0_hi: got %h expected 00000007", hi); end
    vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div0_lo: got %h expected ffffffff", lo); end
    vectors++; if (nb !== 1) begin miscompares++; $display("FAIL div0_busy_cycles: got %0d expected 1", nb); end
  endtask

  task automatic test_mthi_mtlo();
    int wc, nw, nb; logic [31:0] hi, lo; logic hw, lw, dn;
    issue(OP_MTHI, 32'h1234_5678, 32'h0);
    observe(2, wc, nw, nb, hi, lo, hw, lw, dn);
    vectors++; if (wc !== 1) begin miscompares++; $display("FAIL mthi_wr_cycle: got %0d expected 1", wc); end
    vectors++; if ({hw, lw} !== 2'b10) begin miscompares++; $display("FAIL mthi_we: got %b expected 10", {hw, lw}); end
    vectors++; if (hi !== 32'h1234_5678) begin miscompares++; $display("FAIL mthi_data: got %h expected 12345678", hi); end
    vectors++; if (nb !== 1) begin miscompares++; $display("FAIL mthi_busy_cycles: got %0d expected 1", nb); end
    issue(OP_MTLO, 32'hCAFE_F00D, 32'h0);
    observe(2, wc, nw, nb, hi, lo, hw, lw, dn);
    vectors++; if ({hw, lw} !== 2'b01) begin miscompares++; $display("FAIL mtlo_we: got %b expected 01", {hw, lw}); end
    vectors++; if (lo !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL mtlo_data: got %h expected cafef00d", lo); end
  endtask

  // previous op left the sequencer idle in the cycle busy fell; issue immediately
  task automatic test_back_to_back();
    int wc, nw, nb; logic [31:0] hi, lo; logic hw, lw, dn;
    issue(OP_DIVU, 32'd100, 32'd7);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: busy got %b expected 1", busy); end
    observe(34, wc, nw, nb, hi, lo, hw, lw, dn);
    vectors++; if (wc !== 33) begin miscompares++; $display("FAIL b2b_wr_cycle: got %0d expected 33", wc); end
    vectors++; if (lo !== 32'd14) begin miscompares++; $display("FAIL divu_quot: got %h expected 0000000e", lo); end
    vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL divu_rem: got %h expected 00000002", hi); end
  endtask

  task automatic test_stall();
    int c;
    int extra_wr;
    issue(OP_MULT, 32'd3, 32'd5);
    repeat (5) tick();                       // cycle N+6, count=5
    start = 1'b1; op = OP_MULTU; rs_data = 32'd7; rt_data = 32'd9; mf_req = 1'b1;
    #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL stall_busy: got %b expected 1", stall); end
    tick();                                   // cycle N+7
    start = 1'b0; mf_req = 1'b0;
    #1;
    vectors++; if ({busy, stall} !== 2'b10) begin miscompares++; $display("FAIL stall_release: got %b expected 10", {busy, stall}); end
    c = 7;
    while (!(HI_w || LO_w) && c < 40) begin tick(); c++; end
    vectors++; if (c !== 33) begin miscompares++; $display("FAIL stall_wr_cycle: got %0d expected 33", c); end
    vectors++; if ({HI_wdata, LO_wdata} !== {32'd0, 32'd15}) begin miscompares++; $display("FAIL stall_result: got %h_%h expected 00000000_0000000f", HI_wdata, LO_wdata); end
    mf_req = 1'b1;
    #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL stall_in_write: got %b expected 1", stall); end
    tick();                                   // cycle N+34
    vectors++; if ({busy, stall} !== 2'b00) begin miscompares++; $display("FAIL stall_after_write: got %b expected 00", {busy, stall}); end
    mf_req = 1'b0;
    extra_wr = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (HI_w || LO_w || busy) extra_wr++;
    end
    vectors++; if (extra_wr !== 0) begin miscompares++; $display("FAIL stall_ignored_op: activity cycles got %0d expected 0", extra_wr); end
  endtask

  task automatic test_reset_mid_op();
    int wc, nw, nb; logic [31:0] hi, lo; logic hw, lw, dn;
    issue(OP_MULT, 32'd3, 32'd5);
    repeat (10) tick();                       // count=10
    MDU_rst_n = 1'b0;
    tick();
    vectors++; if ({HI_wdata, LO_wdata} !== 64'd0) begin miscompares++; $display("FAIL rstmid_data: got %h_%h expected 0", HI_wdata, LO_wdata); end
    vectors++; if ({HI_w, LO_w, busy, stall, done} !== 5'b0) begin miscompares++; $display("FAIL rstmid_ctl: got %b expected 00000", {HI_w, LO_w, busy, stall, done}); end
    MDU_rst_n = 1'b1;
    observe(40, wc, nw, nb, hi, lo, hw, lw, dn);
    vectors++; if (nw !== 0) begin miscompares++; $display("FAIL rstmid_no_write: got %0d writes expected 0", nw); end
  endtask

  task automatic test_ena_freeze();
    int wc, nw, nb; logic [31:0] hi, lo; logic hw, lw, dn;
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    repeat (10) tick();                       // cycle N+11
    MDU_ena = 1'b0;
    repeat (4) tick();                        // four frozen edges, now cycle N+15
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ena_busy_hold: got %b expected 1", busy); end
    MDU_ena = 1'b1;
    observe(23, wc, nw, nb, hi, lo, hw, lw, dn);   // covers cycles N+15..N+37
    vectors++; if (wc !== 23) begin miscompares++; $display("FAIL ena_wr_delay: write at rel %0d expected 23 (cycle N+37)", wc); end
    vectors++; if ({hi, lo} !== 64'h0000_0001_0000_0000) begin miscompares++; $display("FAIL ena_result: got %h_%h expected 00000001_00000000", hi, lo); end
    tick();
  endtask

  initial begin
    MDU_rst_n = 1'b0; MDU_ena = 1'b1; start = 1'b0; op = 3'b000;
    rs_data = '0; rt_data = '0; mf_req = 1'b0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_by_zero();
    test_mthi_mtlo();
    test_back_to_back();
    test_stall();
    test_reset_mid_op();
    test_ena_freeze();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencer that owns all writes into the HI/LO register pair of the 54-instruction CPU. Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the decode stage. Computes products and quotients iteratively in 32 cycles and drives the HI/LO write data and write enables. Raises a stall to the PC/decode logic while an operation is in flight, and whenever a new HI/LO instruction or an MFHI/MFLO arrives during that time.

## Interface
Parameters:
- ITER, 32: iteration count for multiply/divide; equals operand width.

Ports:
- MDU_clk  in  1  clock; all state updates on rising edge.
- MDU_rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- MDU_ena  in  1  enable; low freezes all state and forces HI_w/LO_w to 0.
- start  in  1  instruction valid; sampled only in IDLE.
- op  in  3  3'b001 MULT, 3'b010 MULTU, 3'b011 DIV, 3'b100 DIVU, 3'b101 MTHI, 3'b110 MTLO; other codes are no-ops.
- rs_data  in  32  multiplicand / dividend / MT source.
- rt_data  in  32  multiplier / divisor.
- mf_req  in  1  current instruction is MFHI/MFLO.
- HI_wdata  out  32  data to the HI register.
- LO_wdata  out  32  data to the LO register.
- HI_w  out  1  HI write enable, one-cycle pulse.
- LO_w  out  1  LO write enable, one-cycle pulse.
- busy  out  1  operation in flight.
- stall  out  1  busy && (start || mf_req).
- done  out  1  one-cycle pulse coincident with the final write.

## Operation
States: IDLE, CALC, WRITE.
- IDLE
  - start && valid op latches op, rs_data, rt_data.
  - MTHI/MTLO go to WRITE.
  - MULT/MULTU/DIV/DIVU go to CALC with count=0.
  - Exception: a divisor of zero goes directly to WRITE.
- CALC
  - One iteration per cycle; count increments 0..ITER-1.
  - Goes to WRITE after count==ITER-1.
- WRITE
  - Drives the results and write enables; returns to IDLE.

Multiply:
- Shift-add on 64-bit {HI,LO} accumulator.
- Signed ops use operand magnitudes, then negate the 64-bit product if the sign bits differ.
- Result: HI=prod[63:32], LO=prod[31:0].

Divide:
- Restoring divide on magnitudes (unsigned for DIVU).
- LO=quotient, HI=remainder.
- Signed: the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
- Overflow case 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero gives HI=rs_data, LO=32'hFFFFFFFF.

MTHI/MTLO:
- HI_wdata (or LO_wdata) = rs_data.
- Only that register's write enable pulses.

Other behaviour:
- A start while busy is ignored. The requester is held by stall and re-presents the instruction after busy falls.
- When MDU_ena is low, state, count and operands hold, and no write enable is asserted.

## Timing
- Reset (MDU_rst_n low at a rising edge):
  - State goes to IDLE and count to 0.
  - HI_wdata=LO_wdata=0; HI_w=LO_w=busy=stall=done=0.
  - Applies in any state. An interrupted operation produces no write.
- Start accepted at edge N:
  - MUL/DIV: CALC occupies cycles N+1..N+32 and WRITE occupies cycle N+33. HI_w=LO_w=done=1 during N+33 only.
  - busy is high for cycles N+1..N+33 and low in N+34.
  - Divide by zero: WRITE in cycle N+1, busy high in N+1 only.
  - MTHI/MTLO: WRITE in cycle N+1. busy is high in N+1 only, and the single write enable is high in N+1.
- Write enables, write data and done are registered outputs, valid for the entire WRITE cycle. They are stable before any consumer edge in that cycle, including a falling-edge HI/LO write.
- stall is combinational from busy, start and mf_req.
- During WRITE, stall is still asserted for mf_req. An MFHI/MFLO issued in the following cycle sees the new value.
- A back-to-back start in the cycle busy falls (IDLE) is accepted with no bubble.

## Test plan
- MULT rs=0xFFFFFFFF, rt=0x00000002 -> at N+33: HI=0xFFFFFFFF, LO=0xFFFFFFFE, HI_w=LO_w=done=1 for exactly one cycle.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE; busy high for exactly 33 cycles.
- DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=7, rt=0 -> at N+1: HI=7, LO=0xFFFFFFFF, busy one cycle. MTHI rs=0x12345678 -> HI_w=1 and LO_w=0 at N+1.
- Start MULT, then assert mf_req and a second start at count=5 -> stall=1, the second op is ignored, and the first result is unchanged.
- MDU_rst_n low at count=10 -> all outputs 0 the next cycle and no HI_w/LO_w pulse afterward. MDU_ena low for 4 cycles mid-CALC -> write delayed by exactly 4 cycles with a correct result.
